// File: rtl/plru_alloc_if.sv
// Allocation handshake bundle between a requester (master) and the
// PLRU allocation controller (slave): request/grant plus a held response.
interface plru_alloc_if #(
  parameter int ENTRIES = 8
);
  localparam int IdxW = $clog2(ENTRIES);

  logic            alloc_req;
  logic            alloc_gnt;
  logic            alloc_rsp_valid;
  logic            alloc_rsp_ready;
  logic [IdxW-1:0] alloc_idx;
  logic            alloc_evict;

  modport master (
    output alloc_req,
    output alloc_rsp_ready,
    input  alloc_gnt,
    input  alloc_rsp_valid,
    input  alloc_idx,
    input  alloc_evict
  );

  modport slave (
    input  alloc_req,
    input  alloc_rsp_ready,
    output alloc_gnt,
    output alloc_rsp_valid,
    output alloc_idx,
    output alloc_evict
  );
endinterface

// File: rtl/plru_alloc_ctrl.sv
// Entry allocation controller: tracks per-entry valid bits and a binary
// pseudo-LRU tree, grants the lowest free entry or the PLRU victim, and
// sequences a one-entry-per-cycle flush.
module plru_alloc_ctrl #(
  parameter int ENTRIES = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  plru_alloc_if.slave                 alloc,
  input  logic                        touch_i,
  input  logic [$clog2(ENTRIES)-1:0]  touch_idx_i,
  input  logic                        inval_i,
  input  logic [$clog2(ENTRIES)-1:0]  inval_idx_i,
  input  logic                        flush_i,
  output logic                        busy_o,
  output logic [ENTRIES-1:0]          valid_o
);
  localparam int IdxW  = $clog2(ENTRIES);
  localparam int Nodes = ENTRIES - 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // Follow node bits from the root; each bit selects the LRU half and
  // becomes the next index bit, MSB first.
  function automatic logic [IdxW-1:0] plru_leaf(input logic [Nodes-1:0] tree);
    int              n;
    logic [IdxW-1:0] leaf;
    n    = 0;
    leaf = '0;
    for (int l = 0; l < IdxW; l++) begin
      leaf[IdxW-1-l] = tree[n];
      n = 2 * n + 1 + int'(tree[n]);
    end
    return leaf;
  endfunction

  // Mark an entry as most recently used: every node on its path points
  // away from it.
  function automatic logic [Nodes-1:0] tree_use(input logic [Nodes-1:0] tree,
                                                input logic [IdxW-1:0]  idx);
    int               n;
    logic             b;
    logic [Nodes-1:0] t;
    n = 0;
    t = tree;
    for (int l = 0; l < IdxW; l++) begin
      b    = idx[IdxW-1-l];
      t[n] = ~b;
      n    = 2 * n + 1 + int'(b);
    end
    return t;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [IdxW-1:0]  cnt_q, cnt_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [Nodes-1:0] tree_q, tree_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IdxW-1:0]  rsp_idx_q, rsp_idx_d;
  logic             rsp_evict_q, rsp_evict_d;

  logic             free_found;
  logic [IdxW-1:0]  free_idx;
  logic [IdxW-1:0]  victim;
  logic             gnt;

  // Lowest-index invalid entry, else the PLRU leaf, from registered state.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
    victim = free_found ? free_idx : plru_leaf(tree_q);
  end

  // Grant only when idle, not flushing, and the response slot frees up.
  assign gnt = !rst_i && (state_q == ST_IDLE) && alloc.alloc_req && !flush_i &&
               (!rsp_valid_q || alloc.alloc_rsp_ready);

  assign alloc.alloc_gnt       = gnt;
  assign alloc.alloc_rsp_valid = rsp_valid_q;
  assign alloc.alloc_idx       = rsp_idx_q;
  assign alloc.alloc_evict     = rsp_evict_q;
  assign busy_o                = (state_q == ST_FLUSH);
  assign valid_o               = valid_q;

  // Next-state: touch then alloc on the tree, inval then alloc on valid
  // bits, response hold/clear, and the flush walk.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    tree_d      = tree_q;
    rsp_valid_d = rsp_valid_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_evict_d = rsp_evict_q;

    if (state_q == ST_IDLE) begin
      if (touch_i && valid_q[touch_idx_i]) begin
        tree_d = tree_use(tree_d, touch_idx_i);
      end
      if (inval_i) begin
        valid_d[inval_idx_i] = 1'b0;
      end
      if (gnt) begin
        tree_d          = tree_use(tree_d, victim);
        valid_d[victim] = 1'b1;
      end
      if (flush_i) begin
        state_d = ST_FLUSH;
        cnt_d   = '0;
      end
    end else begin
      valid_d[cnt_q] = 1'b0;
      cnt_d          = cnt_q + 1'b1;
      if (cnt_q == IdxW'(ENTRIES - 1)) begin
        tree_d  = '0;
        state_d = ST_IDLE;
      end
    end

    if (gnt) begin
      rsp_valid_d = 1'b1;
      rsp_idx_d   = victim;
      rsp_evict_d = valid_q[victim];
    end else if (alloc.alloc_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers; reset discards everything including a pending response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      valid_q     <= '0;
      tree_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_evict_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      tree_q      <= tree_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_evict_q <= rsp_evict_d;
    end
  end
endmodule

// File: tb/tb_plru_alloc_ctrl.sv
// Self-checking bench for plru_alloc_ctrl: directed scenarios followed by
// random traffic, compared against a recency-timestamp reference model.
module tb_plru_alloc_ctrl;
  localparam int ENTRIES = 8;
  localparam int IdxW    = $clog2(ENTRIES);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  plru_alloc_if #(.ENTRIES(ENTRIES)) aif();

  logic               touch_i;
  logic [IdxW-1:0]    touch_idx_i;
  logic               inval_i;
  logic [IdxW-1:0]    inval_idx_i;
  logic               flush_i;
  logic               busy_o;
  logic [ENTRIES-1:0] valid_o;

  plru_alloc_ctrl #(.ENTRIES(ENTRIES)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .alloc      (aif.slave),
    .touch_i    (touch_i),
    .touch_idx_i(touch_idx_i),
    .inval_i    (inval_i),
    .inval_idx_i(inval_idx_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: valid bits plus a last-use timestamp per entry.
  // PLRU victim = descend into the half whose most recent use is older.
  bit          m_valid [ENTRIES];
  int unsigned m_ts    [ENTRIES];
  int unsigned m_tick;
  bit          m_busy;
  int          m_cnt;
  bit          m_rv;
  int          m_ridx;
  bit          m_rev;
  int          busy_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ts[i]    = 0;
    end
    m_tick = 0;
    m_busy = 1'b0;
    m_cnt  = 0;
    m_rv   = 1'b0;
    m_ridx = 0;
    m_rev  = 1'b0;
  endtask

  function automatic int max_ts(input int lo, input int n);
    int unsigned m;
    m = 0;
    for (int i = lo; i < lo + n; i++) if (m_ts[i] > m) m = m_ts[i];
    return int'(m);
  endfunction

  function automatic int m_victim();
    int lo;
    int size;
    int half;
    for (int i = 0; i < ENTRIES; i++) if (!m_valid[i]) return i;
    lo   = 0;
    size = ENTRIES;
    while (size > 1) begin
      half = size / 2;
      if (max_ts(lo, half) > max_ts(lo + half, half)) lo = lo + half;
      size = half;
    end
    return lo;
  endfunction

  function automatic logic [ENTRIES-1:0] m_valid_vec();
    logic [ENTRIES-1:0] v;
    for (int i = 0; i < ENTRIES; i++) v[i] = m_valid[i];
    return v;
  endfunction

  task automatic chk_regs();
    chk("rsp_valid", 32'(aif.alloc_rsp_valid), 32'(m_rv));
    if (m_rv) begin
      chk("rsp_idx", 32'(aif.alloc_idx), 32'(m_ridx));
      chk("rsp_evict", 32'(aif.alloc_evict), 32'(m_rev));
    end
    chk("busy", 32'(busy_o), 32'(m_busy));
    chk("valid_o", 32'(valid_o), 32'(m_valid_vec()));
  endtask

  // One clock: check the combinational grant, advance the model, then
  // check registered outputs just after the edge.
  task automatic cycle();
    bit exp_gnt;
    int v;
    bit n_valid [ENTRIES];
    #1;
    exp_gnt = !m_busy && aif.alloc_req && !flush_i && (!m_rv || aif.alloc_rsp_ready);
    chk("gnt", 32'(aif.alloc_gnt), 32'(exp_gnt));
    v = m_victim();
    n_valid = m_valid;
    if (!m_busy && touch_i && m_valid[touch_idx_i]) begin
      m_tick++;
      m_ts[touch_idx_i] = m_tick;
    end
    if (exp_gnt) begin
      m_tick++;
      m_ts[v] = m_tick;
      m_rev   = m_valid[v];
      m_ridx  = v;
      m_rv    = 1'b1;
    end else if (aif.alloc_rsp_ready) begin
      m_rv = 1'b0;
    end
    if (!m_busy && inval_i) n_valid[inval_idx_i] = 1'b0;
    if (exp_gnt) n_valid[v] = 1'b1;
    if (m_busy) begin
      n_valid[m_cnt] = 1'b0;
      if (m_cnt == ENTRIES - 1) begin
        m_busy = 1'b0;
        for (int i = 0; i < ENTRIES; i++) m_ts[i] = 0;
      end
      m_cnt++;
    end else if (flush_i) begin
      m_busy = 1'b1;
      m_cnt  = 0;
    end
    m_valid = n_valid;
    @(posedge clk);
    #1;
    if (busy_o) busy_cycles++;
    chk_regs();
  endtask

  task automatic idle_inputs();
    aif.alloc_req       = 1'b0;
    aif.alloc_rsp_ready = 1'b1;
    touch_i             = 1'b0;
    touch_idx_i         = '0;
    inval_i             = 1'b0;
    inval_idx_i         = '0;
    flush_i             = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    aif.alloc_req = 1'b1;
    model_reset();
    #3;
    chk("rst_gnt", 32'(aif.alloc_gnt), 32'd0);
    chk("rst_rsp_valid", 32'(aif.alloc_rsp_valid), 32'd0);
    chk("rst_idx", 32'(aif.alloc_idx), 32'd0);
    chk("rst_evict", 32'(aif.alloc_evict), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill 0..7 back to back.
    aif.alloc_req = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      cycle();
      chk("fill_idx", 32'(aif.alloc_idx), 32'(i));
      chk("fill_evict", 32'(aif.alloc_evict), 32'd0);
    end
    chk("fill_valid", 32'(valid_o), 32'hFF);

    // Touch 0, then two PLRU allocations.
    aif.alloc_req = 1'b0;
    touch_i = 1'b1; touch_idx_i = 3'd0;
    cycle();
    touch_i = 1'b0;
    aif.alloc_req = 1'b1;
    cycle();
    chk("plru_idx4", 32'(aif.alloc_idx), 32'd4);
    chk("plru_evict4", 32'(aif.alloc_evict), 32'd1);
    cycle();
    chk("plru_idx2", 32'(aif.alloc_idx), 32'd2);
    chk("plru_evict2", 32'(aif.alloc_evict), 32'd1);

    // Invalidate 5 then 2, allocate twice.
    aif.alloc_req = 1'b0;
    inval_i = 1'b1; inval_idx_i = 3'd5;
    cycle();
    inval_idx_i = 3'd2;
    cycle();
    inval_i = 1'b0;
    aif.alloc_req = 1'b1;
    cycle();
    chk("inval_idx2", 32'(aif.alloc_idx), 32'd2);
    chk("inval_evict2", 32'(aif.alloc_evict), 32'd0);
    cycle();
    chk("inval_idx5", 32'(aif.alloc_idx), 32'd5);
    chk("inval_evict5", 32'(aif.alloc_evict), 32'd0);

    // Backpressure: response held while ready is low.
    aif.alloc_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_idx_hold", 32'(aif.alloc_idx), 32'd5);
    end
    aif.alloc_rsp_ready = 1'b1;
    cycle();

    // Flush together with a request; touch/inval during flush are ignored.
    busy_cycles = 0;
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    aif.alloc_req = 1'b0;
    for (int i = 0; i < ENTRIES + 2; i++) begin
      touch_i = 1'b1; touch_idx_i = IdxW'(i);
      inval_i = 1'b1; inval_idx_i = IdxW'(i + 3);
      cycle();
    end
    touch_i = 1'b0; inval_i = 1'b0;
    chk("flush_busy_cycles", 32'(busy_cycles), 32'(ENTRIES));
    chk("flush_valid", 32'(valid_o), 32'd0);
    aif.alloc_req = 1'b1;
    cycle();
    chk("post_flush_idx", 32'(aif.alloc_idx), 32'd0);
    chk("post_flush_evict", 32'(aif.alloc_evict), 32'd0);
    cycle();

    // Async reset in flush cycle 3 with a response pending.
    aif.alloc_rsp_ready = 1'b0;
    aif.alloc_req = 1'b0;
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_rsp_valid", 32'(aif.alloc_rsp_valid), 32'd0);
    chk("arst_valid", 32'(valid_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    aif.alloc_rsp_ready = 1'b1;
    aif.alloc_req = 1'b1;
    cycle();
    chk("arst_alloc_idx", 32'(aif.alloc_idx), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      aif.alloc_req       = ($urandom_range(0, 1) == 1);
      aif.alloc_rsp_ready = ($urandom_range(0, 3) != 0);
      touch_i             = ($urandom_range(0, 1) == 1);
      touch_idx_i         = IdxW'($urandom_range(0, ENTRIES - 1));
      inval_i             = ($urandom_range(0, 3) == 0);
      inval_idx_i         = IdxW'($urandom_range(0, ENTRIES - 1));
      flush_i             = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
